// File: rtl/avalon_byte_master_pkg.sv
// Shared types for the m1 byte initiator: FSM states, the command bundle and
// the Avalon address width.
package avalon_byte_master_pkg;

    localparam int unsigned M1_ADDR_W = 32;

    typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} master_state_t;

    typedef struct packed {
        logic                 write;
        logic [M1_ADDR_W-1:0] addr;
        logic [7:0]           len;
        logic [7:0]           wdata;
    } byte_cmd_t;

    // A length field of zero stands for a full 256-byte burst.
    function automatic logic [8:0] burst_count(input logic [7:0] len);
        return (len == 8'd0) ? 9'd256 : {1'b0, len};
    endfunction

endpackage

// File: rtl/avalon_byte_master.sv
// Avalon-MM byte initiator: single-byte writes and pipelined sequential burst
// reads with in-order response passthrough and a waitrequest stall timeout.
module avalon_byte_master
    import avalon_byte_master_pkg::*;
#(
    parameter int unsigned MAX_PENDING  = 4,
    parameter int unsigned WAIT_TIMEOUT = 1024
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_write,
    input  logic [M1_ADDR_W-1:0] cmd_addr,
    input  logic [7:0]           cmd_len,
    input  logic [7:0]           cmd_wdata,
    output logic                 rsp_valid,
    output logic [7:0]           rsp_data,
    output logic                 rsp_last,
    output logic                 done,
    output logic                 err,
    output logic [M1_ADDR_W-1:0] m1_address,
    output logic                 m1_read,
    output logic                 m1_write,
    output logic [7:0]           m1_writedata,
    input  logic                 m1_waitrequest,
    input  logic [7:0]           m1_readdata,
    input  logic                 m1_readdatavalid
);

    localparam logic [3:0]  PEND_MAX   = 4'(MAX_PENDING);
    localparam logic [31:0] TIMER_LAST = 32'(WAIT_TIMEOUT - 1);

    master_state_t        state, state_next;
    byte_cmd_t            cmd;
    logic [M1_ADDR_W-1:0] addr;
    logic [7:0]           wdata;
    logic [8:0]           issue_cnt, recv_cnt;
    logic [3:0]           pending;
    logic [31:0]          wait_timer;
    logic                 accept_cmd, accept_rd, rd_take, stall, timeout, done_next;

    assign cmd = '{write: cmd_write, addr: cmd_addr, len: cmd_len, wdata: cmd_wdata};

    assign m1_address   = addr;
    assign m1_writedata = wdata;

    always_comb begin
        cmd_ready  = (state == IDLE);
        accept_cmd = cmd_ready && cmd_valid;
        m1_write   = (state == WRITE);
        // A returning byte frees a slot in the same cycle, so a full window can still issue.
        m1_read    = (state == READ) && (issue_cnt != 9'd0) &&
                     ((pending < PEND_MAX) || (m1_readdatavalid && (pending != 4'd0)));
        accept_rd  = m1_read && !m1_waitrequest;
        // Zero-wait slaves return data in the accept cycle, before pending counts it.
        rd_take    = m1_readdatavalid && ((pending != 4'd0) || accept_rd);
        rsp_valid  = (state == READ) && rd_take;
        rsp_data   = m1_readdata;
        rsp_last   = rsp_valid && (recv_cnt == 9'd1);
        stall      = (m1_read || m1_write) && m1_waitrequest;
        timeout    = (WAIT_TIMEOUT != 0) && stall && (wait_timer == TIMER_LAST);

        state_next = state;
        done_next  = 1'b0;
        unique case (state)
            IDLE:  if (accept_cmd) state_next = cmd.write ? WRITE : READ;
            WRITE: if (!m1_waitrequest) begin
                       state_next = IDLE;
                       done_next  = 1'b1;
                   end
            READ:  if (rsp_valid && (recv_cnt == 9'd1)) begin
                       state_next = IDLE;
                       done_next  = 1'b1;
                   end
            DRAIN: if (pending == 4'd0) begin
                       state_next = IDLE;
                       done_next  = 1'b1;
                   end
            default: state_next = IDLE;
        endcase
        if (timeout) begin
            state_next = DRAIN;
            done_next  = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            addr       <= '0;
            wdata      <= '0;
            issue_cnt  <= '0;
            recv_cnt   <= '0;
            pending    <= '0;
            wait_timer <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            done <= done_next;
            if (accept_cmd) begin
                addr       <= cmd.addr;
                wdata      <= cmd.wdata;
                issue_cnt  <= cmd.write ? 9'd0 : burst_count(cmd.len);
                recv_cnt   <= cmd.write ? 9'd0 : burst_count(cmd.len);
                pending    <= '0;
                wait_timer <= '0;
                err        <= 1'b0;
            end else begin
                if (accept_rd) begin
                    addr      <= addr + M1_ADDR_W'(1);
                    issue_cnt <= issue_cnt - 9'd1;
                end
                if (accept_rd && !rd_take)      pending <= pending + 4'd1;
                else if (!accept_rd && rd_take) pending <= pending - 4'd1;
                if (rsp_valid) recv_cnt <= recv_cnt - 9'd1;
                wait_timer <= stall ? wait_timer + 32'd1 : '0;
                if (timeout) err <= 1'b1;
            end
        end
    end

endmodule

// File: doc/avalon_byte_master.md
Name: avalon_byte_master

Overview:
- Avalon-MM initiator behind the GPU's m1 port.
- Turns internal commands into byte transactions on m1. Commands are either a single-byte write (pixel store) or a sequential burst read of 1..256 bytes (voxel/palette fetch).
- Reads are pipelined up to MAX_PENDING outstanding. Returned bytes stream out in order.
- Honours waitrequest/readdatavalid from both SDRAM (1+ wait cycles) and OCRAM (zero-wait, same-cycle data) slaves, and bounds waitrequest stalls with a timeout.

Parameters:
- MAX_PENDING, 4, maximum accepted reads awaiting readdatavalid (1..15).
- WAIT_TIMEOUT, 1024, consecutive waitrequest-high cycles before the command aborts (0 disables the timeout).

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_write  in  1  1 = single-byte write, 0 = burst read.
- cmd_addr  in  32  byte address of the write, or start address of the read.
- cmd_len  in  8  read length; 0 encodes 256; ignored for writes.
- cmd_wdata  in  8  write byte.
- rsp_valid  out  1  one returned read byte this cycle; no backpressure.
- rsp_data  out  8  returned byte.
- rsp_last  out  1  final byte of the burst.
- done  out  1  one-cycle pulse when a command completes or aborts.
- err  out  1  sticky timeout flag; cleared by accepting the next command.
- m1_address  out  32  Avalon address.
- m1_read  out  1  Avalon read.
- m1_write  out  1  Avalon write.
- m1_writedata  out  8  Avalon write data.
- m1_waitrequest  in  1  slave stall.
- m1_readdata  in  8  read data.
- m1_readdatavalid  in  1  read data valid.

Behaviour:
- Reset values: cmd_ready=1, m1_read=0, m1_write=0, m1_address=0, m1_writedata=0, rsp_valid=0, rsp_last=0, done=0, err=0. State IDLE; all counters 0.
- Reset mid-burst drops everything immediately. Stray readdatavalid after reset is ignored because pending=0.
- Registered command fields: addr, remaining issue count (9 bits), remaining receive count (9 bits), pending count, wait-timer.
- IDLE:
  - cmd_ready=1. On accept, latch the fields, clear err, and go to WRITE or READ.
  - cmd_ready=0 in every other state.
- WRITE:
  - Drive m1_write=1 with m1_address=addr and m1_writedata=wdata.
  - Hold all three unchanged while m1_waitrequest=1.
  - First cycle with m1_waitrequest=0 = accepted: drop m1_write next cycle, pulse done, go to IDLE.
- READ, issue side:
  - Drive m1_read=1 while issue count > 0 and (pending < MAX_PENDING, or a readdatavalid arrives this cycle).
  - A cycle with m1_read=1 and m1_waitrequest=0 is an accepted read: addr+1 (32-bit wrap), issue count-1, pending+1.
  - m1_address and m1_read must stay stable while waitrequest=1.
- READ, receive side:
  - Each m1_readdatavalid cycle with pending > 0: rsp_valid=1 and rsp_data=m1_readdata in the same cycle (combinational passthrough), pending-1, receive count-1.
  - rsp_last=1 when receive count==1.
  - Accept and readdatavalid in the same cycle: pending unchanged (zero-latency slave).
- READ completion: when receive count reaches 0, pulse done the next cycle and go to IDLE. m1_read is already low because issue count is 0.
- Timeout:
  - The wait-timer counts consecutive cycles with (m1_read|m1_write) && m1_waitrequest, and resets on any accepted transfer.
  - At WAIT_TIMEOUT: deassert m1_read/m1_write, set err, go to DRAIN.
- DRAIN:
  - Absorb readdatavalid for outstanding reads without asserting rsp_valid.
  - When pending==0, pulse done and go to IDLE.
- Order guarantee: rsp bytes leave in address order. Exactly len bytes are returned unless err is set.
- m1_read and m1_write are never high together.

Decomposition:
- gpu package:
  - typedef master_state_t {IDLE, WRITE, READ, DRAIN}.
  - typedef byte_cmd_t {write, addr, len, wdata}.
  - constant M1_ADDR_W = 32.
- No sub-module needed: the pending counter and timer are inline. Response passthrough needs no FIFO because there is no backpressure.

Test Plan:
- OCRAM zero-wait, read addr 0x08000000, len 4, memory 11 22 33 44 -> m1_read high 4 consecutive cycles; rsp 11,22,33,44 on those same cycles; rsp_last on 44; done the next cycle.
- SDRAM (1 wait cycle per access), read 0xC0000020, len 3 -> address held through each waitrequest cycle; 3 rsp bytes in order; pending never exceeds MAX_PENDING.
- Write 0xAB to 0xC0000005 with 1 wait cycle -> m1_write held 2 cycles with constant address/data; sdram mem[2][15:8]=0xAB; done pulse once.
- cmd_len=0 to OCRAM -> exactly 256 rsp bytes; rsp_last only on the 256th; address ends at base+0x100.
- Unmapped address 0x00000000 (waitrequest stuck high), WAIT_TIMEOUT=16 -> m1_read drops after 16 cycles; err=1; done pulses; next command is accepted and clears err.
- Reset asserted mid-burst after 2 of 8 bytes -> all outputs at reset values immediately; a new read then completes correctly.
